// File: rtl/lab1_response_checker.sv
// Response checker for the Lab1 four-input function: waits for each applied vector
// to settle, compares f against TRUTH, and accumulates errors and vector coverage.
module lab1_response_checker #(
  parameter logic [15:0] TRUTH  = 16'h0000,
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        f,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [15:0] coverage,
  output logic        fail_valid,
  output logic [3:0]  fail_idx
);

  // state      | meaning
  // ST_IDLE    | waiting for start after reset
  // ST_ARM     | latch current vector as new, load settle counter
  // ST_SETTLE  | count down settle time; hold_q marks an already-sampled stable vector
  // ST_SAMPLE  | compare f against TRUTH, update errors and coverage
  // ST_DONE    | all 16 vectors covered, results frozen
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  vec_q, vec_d;
  logic        hold_q, hold_d;
  logic [4:0]  err_q, err_d;
  logic [15:0] cov_q, cov_d;
  logic        fail_valid_q, fail_valid_d;
  logic [3:0]  fail_idx_q, fail_idx_d;

  logic [3:0]  idx;
  logic        mismatch;
  logic [15:0] cov_next;

  assign idx = {a, b, c, d};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vec_d        = idx;
    hold_d       = hold_q;
    err_d        = err_q;
    cov_d        = cov_q;
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    mismatch     = (f != TRUTH[idx]);
    cov_next     = cov_q | (16'b1 << idx);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_d        = '0;
          cov_d        = '0;
          fail_valid_d = 1'b0;
          fail_idx_d   = '0;
          state_d      = ST_ARM;
        end
      end
      ST_ARM: begin
        cnt_d   = SETTLE_CNT;
        hold_d  = 1'b0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (idx != vec_q) begin
          cnt_d  = SETTLE_CNT;
          hold_d = 1'b0;
        end else if (hold_q) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_q != 5'd31) err_d = err_q + 5'd1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = idx;
          end
        end
        cov_d = cov_next;
        if (cov_next == 16'hFFFF) begin
          state_d = ST_DONE;
        end else if (idx != vec_q) begin
          cnt_d   = SETTLE_CNT;
          hold_d  = 1'b0;
          state_d = ST_SETTLE;
        end else begin
          // Stay parked on this vector until it changes so it is not counted twice.
          cnt_d   = '0;
          hold_d  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vec_q        <= '0;
      hold_q       <= 1'b0;
      err_q        <= '0;
      cov_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_q        <= vec_d;
      hold_q       <= hold_d;
      err_q        <= err_d;
      cov_q        <= cov_d;
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign busy       = (state_q == ST_ARM) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == 5'd0);
  assign err_count  = err_q;
  assign coverage   = cov_q;
  assign fail_valid = fail_valid_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_lab1_response_checker.sv
// Bench for lab1_response_checker: directed scenarios plus a random segment phase,
// checked against a per-vector reference model of the checking rules.
module tb_lab1_response_checker;

  localparam logic [15:0] TRUTH_A = 16'hB3C5;
  localparam logic [15:0] TRUTH_B = 16'hFFFF;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n, start, a, b, c, d, f, f2;
  logic busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [15:0] coverage;
  logic [3:0] fail_idx;
  logic busy2, done2, pass2, fail_valid2;
  logic [4:0] err_count2;
  logic [15:0] coverage2;
  logic [3:0] fail_idx2;

  int tests = 0;
  int fails = 0;

  logic [15:0] truth_v;
  int m_err, m_fidx;
  logic [15:0] m_cov;
  bit m_fv, m_busy, m_done;

  always #5 clk = ~clk;

  lab1_response_checker #(.TRUTH(TRUTH_A), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .d(d), .f(f),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .coverage(coverage),
    .fail_valid(fail_valid), .fail_idx(fail_idx)
  );

  // Second checker sees the same vectors but a stuck-at-0 response and an all-ones table.
  lab1_response_checker #(.TRUTH(TRUTH_B), .SETTLE(S)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c), .d(d), .f(f2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2), .coverage(coverage2),
    .fail_valid(fail_valid2), .fail_idx(fail_idx2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_err = 0; m_fidx = 0; m_cov = '0; m_fv = 0; m_busy = 0; m_done = 0;
  endtask

  // One stable vector held long enough to be judged.
  task automatic model_sample(input int v, input bit fv);
    if (!m_busy) return;
    if (fv != truth_v[v]) begin
      if (m_err < 31) m_err++;
      if (!m_fv) begin
        m_fv = 1;
        m_fidx = v;
      end
    end
    m_cov[v] = 1'b1;
    if (m_cov == 16'hFFFF) begin
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(done), 32'(m_done));
    chk({tag, ".pass"}, 32'(pass), 32'(m_done && (m_err == 0)));
    chk({tag, ".err"}, 32'(err_count), 32'(m_err));
    chk({tag, ".cov"}, 32'(coverage), 32'(m_cov));
    chk({tag, ".fvalid"}, 32'(fail_valid), 32'(m_fv));
    chk({tag, ".fidx"}, 32'(fail_idx), 32'(m_fidx));
  endtask

  task automatic set_vec(input int v, input bit fv);
    {a, b, c, d} = 4'(v);
    f = fv;
  endtask

  // A segment of h cycles: sampled when h >= S+3, discarded when h <= S+1.
  task automatic apply(input int v, input bit fv, input int h, input string tag);
    set_vec(v, fv);
    repeat (h) step();
    if (h >= S + 3) model_sample(v, fv);
    check_all(tag);
  endtask

  task automatic start_run(input int v, input bit fv, input int h, input string tag);
    set_vec(v, fv);
    start = 1'b1;
    step();
    start = 1'b0;
    if (!m_busy) begin
      model_reset();
      m_busy = 1;
    end
    check_all({tag, ".arm"});
    repeat (h) step();
    if (h >= S + 3) model_sample(v, fv);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    step();
    model_reset();
    check_all(tag);
    chk({tag, ".busy2"}, 32'(busy2), 32'd0);
    chk({tag, ".err2"}, 32'(err_count2), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic sweep(input int fault_idx, input string tag);
    for (int v = 0; v < 16; v++) begin
      bit fv;
      fv = truth_v[v] ^ (v == fault_idx);
      if (v == 0) start_run(v, fv, 10, tag);
      else apply(v, fv, 10, tag);
    end
  endtask

  initial begin
    truth_v = TRUTH_A;
    rst_n = 1'b0; start = 1'b0; f2 = 1'b0;
    set_vec(0, 1'b0);
    model_reset();
    repeat (3) step();
    check_all("reset");
    chk("reset.coverage2", 32'(coverage2), 32'd0);
    rst_n = 1'b1;
    step();
    check_all("idle");

    // Correct DUT, ascending sweep.
    sweep(-1, "sweep");
    chk("sweep.done", 32'(done), 32'd1);
    chk("sweep.pass", 32'(pass), 32'd1);
    chk("sweep.cov", 32'(coverage), 32'h0000FFFF);

    // Restart from DONE, single fault at vector 9.
    sweep(9, "fault9");
    chk("fault9.err", 32'(err_count), 32'd1);
    chk("fault9.fidx", 32'(fail_idx), 32'd9);
    chk("fault9.pass", 32'(pass), 32'd0);

    // Glitch rejection: vector 5 held too briefly with a wrong response.
    start_run(6, truth_v[6], 10, "glitch.pre");
    apply(5, ~truth_v[5], 2, "glitch.short");
    apply(6, truth_v[6], 10, "glitch.post");
    chk("glitch.cov5", 32'(coverage[5]), 32'd0);
    chk("glitch.err", 32'(err_count), 32'd0);
    apply(7, ~truth_v[7], 10, "glitch.err7");

    // start while busy is ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    check_all("start_busy");

    do_reset("rst_mid");

    // Alternating repeats with wrong responses saturate the error count.
    start_run(3, ~truth_v[3], 8, "sat");
    for (int i = 1; i < 40; i++) begin
      int v;
      v = (i % 2 == 1) ? 4 : 3;
      apply(v, ~truth_v[v], 8, "sat");
    end
    chk("sat.err", 32'(err_count), 32'd31);
    chk("sat.cov", 32'(coverage), 32'h00000018);
    chk("sat.done", 32'(done), 32'd0);

    do_reset("rst_sat");

    // Stuck-at-0 response, two sweeps; the run ends after the first.
    for (int p = 0; p < 2; p++) begin
      for (int v = 0; v < 16; v++) begin
        if (p == 0 && v == 0) start_run(v, 1'b0, 9, "stuck");
        else apply(v, 1'b0, 9, "stuck");
        if (p == 0 && v == 14) chk("stuck2.done15", 32'(done2), 32'd0);
        if (p == 0 && v == 15) chk("stuck2.done16", 32'(done2), 32'd1);
      end
    end
    chk("stuck2.err", 32'(err_count2), 32'd16);
    chk("stuck2.fidx", 32'(fail_idx2), 32'd0);
    chk("stuck2.fvalid", 32'(fail_valid2), 32'd1);
    chk("stuck2.pass", 32'(pass2), 32'd0);
    chk("stuck2.cov", 32'(coverage2), 32'h0000FFFF);

    // Random segments: random vectors, responses, and hold lengths.
    do_reset("rst_rand");
    begin
      int prev, v, h;
      bit fv;
      prev = int'($urandom_range(0, 15));
      start_run(prev, 1'($urandom_range(0, 1)), S + 3, "rand.first");
      for (int i = 0; i < 300 && !m_done; i++) begin
        v = int'($urandom_range(0, 14));
        if (v >= prev) v++;
        fv = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 2) == 0) h = int'($urandom_range(1, S + 1));
        else h = int'($urandom_range(S + 3, S + 12));
        apply(v, fv, h, "rand");
        prev = v;
      end
    end

    // Restart after done clears results and goes busy.
    if (m_done) start_run(2, truth_v[2], 8, "restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
